inferno_stick_decoder: RTL



---
 rtl/inferno_input_pkg.sv | 61 ++++++
 rtl/inferno_stick_decoder_stick_channel.sv | 68 ++++++
 rtl/inferno_stick_decoder.sv | 70 +++++++
 3 files changed

// File: rtl/inferno_input_pkg.sv
// Shared definitions for the Inferno stick decoder: direction bit positions,
// axis hysteresis states, default thresholds and the direction helpers.
package inferno_input_pkg;

    localparam int DIR_UP    = 3;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_RIGHT = 0;

    localparam int DEAD_ON_DEF       = 48;
    localparam int DEAD_OFF_DEF      = 32;
    localparam int STABLE_CYCLES_DEF = 1200;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        POS  = 2'd1,
        NEG  = 2'd2
    } axis_state_t;

    // Opposing pairs cancel; diagonals pass through untouched.
    function automatic logic [3:0] clean_dir(input logic [3:0] d);
        logic [3:0] r;
        r = d;
        if (d[DIR_UP] && d[DIR_DOWN]) begin
            r[DIR_UP]   = 1'b0;
            r[DIR_DOWN] = 1'b0;
        end
        if (d[DIR_LEFT] && d[DIR_RIGHT]) begin
            r[DIR_LEFT]  = 1'b0;
            r[DIR_RIGHT] = 1'b0;
        end
        return r;
    endfunction

    // 9-bit magnitude so that -128 maps to 128 rather than wrapping.
    function automatic axis_state_t axis_next(input axis_state_t cur,
                                              input logic [7:0]  v,
                                              input logic [8:0]  on_th,
                                              input logic [8:0]  off_th);
        logic        neg;
        logic [8:0]  mag;
        logic        pos_on;
        logic        neg_on;
        logic        pos_hold;
        logic        neg_hold;
        axis_state_t nxt;
        neg      = v[7];
        mag      = neg ? (9'd0 - {1'b1, v}) : {1'b0, v};
        pos_on   = !neg && (mag >= on_th);
        neg_on   = neg && (mag >= on_th);
        pos_hold = !neg && (mag >= off_th);
        neg_hold = neg && (mag >= off_th);
        case (cur)
            POS:     nxt = pos_hold ? POS : (neg_on ? NEG : NONE);
            NEG:     nxt = neg_hold ? NEG : (pos_on ? POS : NONE);
            default: nxt = pos_on ? POS : (neg_on ? NEG : NONE);
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/inferno_stick_decoder_stick_channel.sv
// One analog stick: X/Y hysteresis FSMs feeding a per-stick stability filter.
//  state | meaning
//  NONE  | axis inside the dead zone
//  POS   | axis asserted toward +v (right / down)
//  NEG   | axis asserted toward -v (left / up)
module stick_channel
    import inferno_input_pkg::*;
#(
    parameter int DEAD_ON       = DEAD_ON_DEF,
    parameter int DEAD_OFF      = DEAD_OFF_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [15:0] analog,
    output logic [3:0]  deb
);

    localparam logic [8:0] ON9   = 9'(DEAD_ON);
    localparam logic [8:0] OFF9  = 9'(DEAD_OFF);
    localparam int         CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    axis_state_t      x_st, y_st, x_nxt, y_nxt;
    logic [3:0]       raw;
    logic [3:0]       cand;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            x_st <= NONE;
            y_st <= NONE;
        end else begin
            x_st <= x_nxt;
            y_st <= y_nxt;
        end
    end

    always_comb begin
        x_nxt = axis_next(x_st, analog[7:0], ON9, OFF9);
        y_nxt = axis_next(y_st, analog[15:8], ON9, OFF9);
    end

    always_comb begin
        raw            = '0;
        raw[DIR_UP]    = (y_st == NEG);
        raw[DIR_DOWN]  = (y_st == POS);
        raw[DIR_LEFT]  = (x_st == NEG);
        raw[DIR_RIGHT] = (x_st == POS);
    end

    // Counter saturates at the last value, so deb is simply re-loaded with cand.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cand <= '0;
            cnt  <= '0;
            deb  <= '0;
        end else if (raw != cand) begin
            cand <= raw;
            cnt  <= '0;
        end else if (cnt == CNT_LAST) begin
            deb  <= cand;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/inferno_stick_decoder.sv
// Turns four analog sticks and two D-pads into filtered run/aim direction
// vectors {up,down,left,right} for the Williams-2 Inferno core.
module inferno_stick_decoder
    import inferno_input_pkg::*;
#(
    parameter int DEAD_ON       = DEAD_ON_DEF,
    parameter int DEAD_OFF      = DEAD_OFF_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [3:0]  dig_1,
    input  logic [3:0]  dig_2,
    input  logic [15:0] l_analog_1,
    input  logic [15:0] l_analog_2,
    input  logic [15:0] r_analog_1,
    input  logic [15:0] r_analog_2,
    output logic [3:0]  run_1,
    output logic [3:0]  run_2,
    output logic [3:0]  aim_1,
    output logic [3:0]  aim_2
);

    logic [3:0]  dig_1_q, dig_2_q;
    logic [15:0] l_analog_1_q, l_analog_2_q, r_analog_1_q, r_analog_2_q;
    logic [3:0]  deb_l1, deb_l2, deb_r1, deb_r2;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dig_1_q      <= '0;
            dig_2_q      <= '0;
            l_analog_1_q <= '0;
            l_analog_2_q <= '0;
            r_analog_1_q <= '0;
            r_analog_2_q <= '0;
        end else begin
            dig_1_q      <= dig_1;
            dig_2_q      <= dig_2;
            l_analog_1_q <= l_analog_1;
            l_analog_2_q <= l_analog_2;
            r_analog_1_q <= r_analog_1;
            r_analog_2_q <= r_analog_2;
        end
    end

    stick_channel #(.DEAD_ON(DEAD_ON), .DEAD_OFF(DEAD_OFF), .STABLE_CYCLES(STABLE_CYCLES))
        u_l1 (.clk_sys(clk_sys), .reset_n(reset_n), .analog(l_analog_1_q), .deb(deb_l1));
    stick_channel #(.DEAD_ON(DEAD_ON), .DEAD_OFF(DEAD_OFF), .STABLE_CYCLES(STABLE_CYCLES))
        u_l2 (.clk_sys(clk_sys), .reset_n(reset_n), .analog(l_analog_2_q), .deb(deb_l2));
    stick_channel #(.DEAD_ON(DEAD_ON), .DEAD_OFF(DEAD_OFF), .STABLE_CYCLES(STABLE_CYCLES))
        u_r1 (.clk_sys(clk_sys), .reset_n(reset_n), .analog(r_analog_1_q), .deb(deb_r1));
    stick_channel #(.DEAD_ON(DEAD_ON), .DEAD_OFF(DEAD_OFF), .STABLE_CYCLES(STABLE_CYCLES))
        u_r2 (.clk_sys(clk_sys), .reset_n(reset_n), .analog(r_analog_2_q), .deb(deb_r2));

    // The D-pad joins after the filter so it reaches run_n one edge after capture.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            run_1 <= '0;
            run_2 <= '0;
            aim_1 <= '0;
            aim_2 <= '0;
        end else begin
            run_1 <= clean_dir(deb_l1 | dig_1_q);
            run_2 <= clean_dir(deb_l2 | dig_2_q);
            aim_1 <= deb_r1;
            aim_2 <= deb_r2;
        end
    end

endmodule
